// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, state encoding and constants for the execute/writeback stage.
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  localparam int MUL_CYCLES = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  // Opcodes 0..9 are single-cycle ALU operations that write back.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_LDI;
  endfunction

endpackage

// File: rtl/exec_if.sv
// exec_if: decoder-to-execute instruction handshake.
interface exec_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [AW-1:0] rd;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [7:0]    imm;

  modport master (
    output in_valid, opcode, rd, ra, rb, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, opcode, rd, ra, rb, imm,
    output in_ready
  );
endinterface

// File: rtl/seq_mul16.sv
// seq_mul16: iterative 16x16 shift-add multiplier keeping the low 16 product bits.
// The start edge performs the first iteration; done pulses for one cycle after the 16th.
module seq_mul16
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [15:0] product
);

  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [4:0]  count;
  logic        running;

  // One shift-add iteration per clock; the partial product accumulates in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      product <= b[0] ? a : '0;
      mcand   <= {a[14:0], 1'b0};
      mplier  <= {1'b0, b[15:1]};
      count   <= 5'd1;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      product <= product + (mplier[0] ? mcand : '0);
      mcand   <= {mcand[14:0], 1'b0};
      mplier  <= {1'b0, mplier[15:1]};
      count   <= count + 5'd1;
      if (count == 5'(MUL_CYCLES - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: single-issue execute/writeback stage in front of an 8x16 register file.
// Optional multiplier: define EXEC_MUL_EN to include seq_mul16 and the MUL state;
// without it opcode A is treated as a NOP.
module exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  exec_if.slave            dec,
  output logic [AW-1:0]    RA_addr,
  output logic [AW-1:0]    RB_addr,
  input  logic [WIDTH-1:0] RA_data,
  input  logic [WIDTH-1:0] RB_data,
  output logic [WIDTH-1:0] WR_data,
  output logic [AW-1:0]    WR_addr,
  output logic             WE,
  output logic             flag_z,
  output logic             flag_c,
  output logic             busy
);

  state_t        state;
  logic          addr_phase;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] ra_q;
  logic [AW-1:0] rb_q;
  logic [7:0]    imm_q;
  logic          carry_q;
  logic          sets_c_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_sets_c;
  logic [WIDTH:0]   sum_ext;

  // ALU on the register-file read data; only ADD/SUB/SHL/SHR produce a carry.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_sets_c = 1'b0;
    sum_ext    = '0;
    case (op_q)
      OP_ADD: begin
        sum_ext    = {1'b0, RA_data} + {1'b0, RB_data};
        alu_result = sum_ext[WIDTH-1:0];
        alu_carry  = sum_ext[WIDTH];
        alu_sets_c = 1'b1;
      end
      OP_SUB: begin
        sum_ext    = {1'b0, RA_data} - {1'b0, RB_data};
        alu_result = sum_ext[WIDTH-1:0];
        alu_carry  = sum_ext[WIDTH];
        alu_sets_c = 1'b1;
      end
      OP_AND: alu_result = RA_data & RB_data;
      OP_OR:  alu_result = RA_data | RB_data;
      OP_XOR: alu_result = RA_data ^ RB_data;
      OP_NOT: alu_result = ~RA_data;
      OP_SHL: begin
        alu_result = {RA_data[WIDTH-2:0], 1'b0};
        alu_carry  = RA_data[WIDTH-1];
        alu_sets_c = 1'b1;
      end
      OP_SHR: begin
        alu_result = {1'b0, RA_data[WIDTH-1:1]};
        alu_carry  = RA_data[0];
        alu_sets_c = 1'b1;
      end
      OP_MOV: alu_result = RA_data;
      OP_LDI: alu_result = {{(WIDTH-8){1'b0}}, imm_q};
      default: alu_result = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // The multiplier takes its operands straight from the read ports on the last EXEC cycle.
  always_comb begin
    mul_start = (state == S_EXEC) && !addr_phase && (op_q == OP_MUL);
  end

  seq_mul16 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (RA_data),
    .b       (RB_data),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Control FSM with registered handshake, read-address, writeback and flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_phase   <= 1'b0;
      op_q         <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      imm_q        <= '0;
      carry_q      <= 1'b0;
      sets_c_q     <= 1'b0;
      RA_addr      <= '0;
      RB_addr      <= '0;
      WR_data      <= '0;
      WR_addr      <= '0;
      WE           <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      busy         <= 1'b0;
      dec.in_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (dec.in_valid && dec.in_ready) begin
            op_q         <= dec.opcode;
            rd_q         <= dec.rd;
            ra_q         <= dec.ra;
            rb_q         <= dec.rb;
            imm_q        <= dec.imm;
            addr_phase   <= 1'b1;
            state        <= S_EXEC;
            dec.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_EXEC: begin
          if (addr_phase) begin
            RA_addr    <= ra_q;
            RB_addr    <= rb_q;
            addr_phase <= 1'b0;
`ifdef EXEC_MUL_EN
          end else if (op_q == OP_MUL) begin
            state <= S_MUL;
`endif
          end else if (is_alu_op(op_q)) begin
            WR_data  <= alu_result;
            WR_addr  <= rd_q;
            WE       <= 1'b1;
            carry_q  <= alu_carry;
            sets_c_q <= alu_sets_c;
            state    <= S_WB;
          end else begin
            state        <= S_IDLE;
            dec.in_ready <= 1'b1;
            busy         <= 1'b0;
          end
        end
`ifdef EXEC_MUL_EN
        S_MUL: begin
          if (mul_done) begin
            WR_data  <= mul_product;
            WR_addr  <= rd_q;
            WE       <= 1'b1;
            sets_c_q <= 1'b0;
            state    <= S_WB;
          end
        end
`endif
        S_WB: begin
          WE     <= 1'b0;
          flag_z <= (WR_data == '0);
          if (sets_c_q) begin
            flag_c <= carry_q;
          end
          state        <= S_IDLE;
          dec.in_ready <= 1'b1;
          busy         <= 1'b0;
        end
        default: begin
          WE           <= 1'b0;
          state        <= S_IDLE;
          dec.in_ready <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: table-driven bench with a writeback scoreboard and a behavioural register file.
module tb_exec_stage;
  import exec_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  RA_addr, RB_addr, WR_addr;
  logic [15:0] RA_data, RB_data, WR_data;
  logic        WE, flag_z, flag_c, busy;

  exec_if #(.AW(3)) dec_bus ();

  exec_stage #(.WIDTH(16), .AW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .dec     (dec_bus),
    .RA_addr (RA_addr),
    .RB_addr (RB_addr),
    .RA_data (RA_data),
    .RB_data (RB_data),
    .WR_data (WR_data),
    .WR_addr (WR_addr),
    .WE      (WE),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .busy    (busy)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [7:0]  imm;
    logic        exp_we;
    logic [15:0] exp_data;
    logic        exp_z, exp_c;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t  sb_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  logic [15:0] regs [8] = '{default: 16'h0000};
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign RA_data = regs[RA_addr];
  assign RB_data = regs[RB_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: DUT writeback, or a bench preload when idle.
  always @(posedge clk) begin
    if (WE) regs[WR_addr] <= WR_data;
    else if (pl_en) regs[pl_addr] <= pl_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Scoreboard: every WE pulse must match the oldest pending expected write.
  always @(negedge clk) begin
    if (!rst && WE) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected WE", 32'(WR_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = sb_q.pop_front();
        checkOutput("WR_addr", 32'(WR_addr), 32'(w.addr));
        checkOutput("WR_data", 32'(WR_data), 32'(w.data));
      end
    end
  end

  function automatic vec_t mk(string n, logic [3:0] op, logic [2:0] rd, logic [2:0] ra, logic [2:0] rb,
                              logic [7:0] imm, logic we, logic [15:0] d, logic z, logic c, int cyc);
    vec_t v;
    v.name = n; v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
    v.exp_we = we; v.exp_data = d; v.exp_z = z; v.exp_c = c; v.exp_cycles = cyc;
    return v;
  endfunction

  task automatic waitReady();
    int guard = 0;
    @(negedge clk);
    while (!dec_bus.in_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!dec_bus.in_ready) checkOutput("ready timeout", 32'(dec_bus.in_ready), 32'd1);
  endtask

  task automatic driveFields(input vec_t v);
    dec_bus.opcode = v.op;
    dec_bus.rd     = v.rd;
    dec_bus.ra     = v.ra;
    dec_bus.rb     = v.rb;
    dec_bus.imm    = v.imm;
    if (v.exp_we) sb_q.push_back('{addr: v.rd, data: v.exp_data});
  endtask

  // Count negedges with in_ready low, starting just after an accept edge.
  task automatic countBusy(output int low);
    low = 0;
    @(negedge clk);
    while (!dec_bus.in_ready && low < 60) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int low);
    waitReady();
    driveFields(v);
    dec_bus.in_valid = 1'b1;
    @(posedge clk);
    #1 dec_bus.in_valid = 1'b0;
    countBusy(low);
  endtask

  task automatic preloadReg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   low;

    vecs.push_back(mk("LDI r1 23",    OP_LDI, 3'd1, 3'd0, 3'd0, 8'h23, 1, 16'h0023, 0, 0, 3));
    vecs.push_back(mk("LDI r5 00",    OP_LDI, 3'd5, 3'd0, 3'd0, 8'h00, 1, 16'h0000, 1, 0, 3));
    vecs.push_back(mk("NOT r1 r5",    OP_NOT, 3'd1, 3'd5, 3'd0, 8'h00, 1, 16'hFFFF, 0, 0, 3));
    vecs.push_back(mk("LDI r2 01",    OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01, 1, 16'h0001, 0, 0, 3));
    vecs.push_back(mk("ADD carry",    OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1, 16'h0000, 1, 1, 3));
    vecs.push_back(mk("LDI r1 01",    OP_LDI, 3'd1, 3'd0, 3'd0, 8'h01, 1, 16'h0001, 0, 1, 3));
    vecs.push_back(mk("LDI r2 02",    OP_LDI, 3'd2, 3'd0, 3'd0, 8'h02, 1, 16'h0002, 0, 1, 3));
    vecs.push_back(mk("SUB borrow",   OP_SUB, 3'd4, 3'd1, 3'd2, 8'h00, 1, 16'hFFFF, 0, 1, 3));
    vecs.push_back(mk("SHR r7 r2",    OP_SHR, 3'd7, 3'd2, 3'd0, 8'h00, 1, 16'h0001, 0, 0, 3));
    vecs.push_back(mk("SHL r6 r4",    OP_SHL, 3'd6, 3'd4, 3'd0, 8'h00, 1, 16'hFFFE, 0, 1, 3));
    vecs.push_back(mk("AND keeps c",  OP_AND, 3'd0, 3'd4, 3'd2, 8'h00, 1, 16'h0002, 0, 1, 3));
    vecs.push_back(mk("OR r0",        OP_OR,  3'd0, 3'd1, 3'd2, 8'h00, 1, 16'h0003, 0, 1, 3));
    vecs.push_back(mk("XOR r6",       OP_XOR, 3'd6, 3'd1, 3'd4, 8'h00, 1, 16'hFFFE, 0, 1, 3));
    vecs.push_back(mk("MOV r0 r7",    OP_MOV, 3'd0, 3'd7, 3'd0, 8'h00, 1, 16'h0001, 0, 1, 3));
    vecs.push_back(mk("NOP B",        4'hB,   3'd2, 3'd1, 3'd1, 8'h00, 0, 16'h0000, 0, 1, 2));
    vecs.push_back(mk("LDI r1 91",    OP_LDI, 3'd1, 3'd0, 3'd0, 8'h91, 1, 16'h0091, 0, 1, 3));
    vecs.push_back(mk("SHL r1 r1",    OP_SHL, 3'd1, 3'd1, 3'd0, 8'h00, 1, 16'h0122, 0, 0, 3));
    vecs.push_back(mk("LDI r2 01b",   OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01, 1, 16'h0001, 0, 0, 3));
    vecs.push_back(mk("OR r1 0123",   OP_OR,  3'd1, 3'd1, 3'd2, 8'h00, 1, 16'h0123, 0, 0, 3));
    vecs.push_back(mk("LDI r2 10",    OP_LDI, 3'd2, 3'd0, 3'd0, 8'h10, 1, 16'h0010, 0, 0, 3));
    vecs.push_back(mk("SUB zero",     OP_SUB, 3'd0, 3'd2, 3'd2, 8'h00, 1, 16'h0000, 1, 0, 3));
`ifdef EXEC_MUL_EN
    vecs.push_back(mk("MUL",          OP_MUL, 3'd5, 3'd1, 3'd2, 8'h00, 1, 16'h1230, 0, 0, 19));
`else
    vecs.push_back(mk("MUL as NOP",   OP_MUL, 3'd5, 3'd1, 3'd2, 8'h00, 0, 16'h0000, 1, 0, 2));
`endif
    vecs.push_back(mk("NOP F",        4'hF,   3'd3, 3'd0, 3'd0, 8'h00, 0, 16'h0000, flag_z_after_mul(), 0, 2));

    dec_bus.in_valid = 1'b0;
    dec_bus.opcode = '0; dec_bus.rd = '0; dec_bus.ra = '0; dec_bus.rb = '0; dec_bus.imm = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset WE",       32'(WE),               32'd0);
    checkOutput("reset WR_data",  32'(WR_data),          32'd0);
    checkOutput("reset WR_addr",  32'(WR_addr),          32'd0);
    checkOutput("reset RA_addr",  32'(RA_addr),          32'd0);
    checkOutput("reset RB_addr",  32'(RB_addr),          32'd0);
    checkOutput("reset flag_z",   32'(flag_z),           32'd0);
    checkOutput("reset flag_c",   32'(flag_c),           32'd0);
    checkOutput("reset busy",     32'(busy),             32'd0);
    checkOutput("reset in_ready", 32'(dec_bus.in_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v, low);
      checkOutput({v.name, " cycles"},  32'(low),        32'(v.exp_cycles));
      checkOutput({v.name, " flag_z"},  32'(flag_z),     32'(v.exp_z));
      checkOutput({v.name, " flag_c"},  32'(flag_c),     32'(v.exp_c));
      checkOutput({v.name, " pending"}, 32'(sb_q.size()), 32'd0);
    end

    // Reset in the middle of an instruction: no write, rd keeps its value.
    $display("[TB] reset mid-operation");
`ifdef EXEC_MUL_EN
    v = mk("MUL reset", OP_MUL, 3'd1, 3'd2, 3'd2, 8'h00, 0, 16'h0000, 0, 0, 0);
`else
    v = mk("ADD reset", OP_ADD, 3'd1, 3'd2, 3'd2, 8'h00, 0, 16'h0000, 0, 0, 0);
`endif
    waitReady();
    driveFields(v);
    dec_bus.in_valid = 1'b1;
    @(posedge clk);
    #1 dec_bus.in_valid = 1'b0;
`ifdef EXEC_MUL_EN
    repeat (5) @(posedge clk);
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset WE",       32'(WE),               32'd0);
    checkOutput("midreset in_ready", 32'(dec_bus.in_ready), 32'd1);
    checkOutput("midreset busy",     32'(busy),             32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midreset r1 kept", 32'(regs[1]), 32'h0123);
    checkOutput("midreset flag_z",  32'(flag_z),  32'd0);
    checkOutput("midreset flag_c",  32'(flag_c),  32'd0);
    applyStimulus(mk("MOV after reset", OP_MOV, 3'd3, 3'd1, 3'd0, 8'h00, 1, 16'h0123, 0, 0, 3), low);
    checkOutput("post-reset cycles",  32'(low),          32'd3);
    checkOutput("post-reset pending", 32'(sb_q.size()),  32'd0);

    // Back-to-back: in_valid held high, XOR consumes the ADD result.
    $display("[TB] back-to-back ADD then XOR");
    preloadReg(3'd6, 16'hAAAA);
    preloadReg(3'd7, 16'h0123);
    waitReady();
    driveFields(mk("ADD b2b", OP_ADD, 3'd4, 3'd6, 3'd7, 8'h00, 1, 16'hABCD, 0, 0, 3));
    dec_bus.in_valid = 1'b1;
    @(posedge clk);
    #1 driveFields(mk("XOR b2b", OP_XOR, 3'd5, 3'd4, 3'd7, 8'h00, 1, 16'hAAEE, 0, 0, 3));
    countBusy(low);
    checkOutput("b2b gap", 32'(low), 32'd3);
    @(posedge clk);
    #1 dec_bus.in_valid = 1'b0;
    countBusy(low);
    checkOutput("b2b second cycles", 32'(low),         32'd3);
    checkOutput("b2b pending",       32'(sb_q.size()), 32'd0);
    checkOutput("b2b r5",            32'(regs[5]),     32'h0000AAEE);
    checkOutput("b2b flag_z",        32'(flag_z),      32'd0);
    checkOutput("b2b flag_c",        32'(flag_c),      32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // flag_z seen by the trailing NOP: the MUL result 0x1230 clears it, a NOP'd MUL leaves it set.
  function automatic logic flag_z_after_mul();
`ifdef EXEC_MUL_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

endmodule
